match_event_counter: RTL

//  Downstream stage of the serial pattern detector. Counts the detector's
//  one-cycle match pulses (y) over fixed windows of WINDOW clock cycles and

---
 rtl/match_event_counter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/match_event_counter.sv
// Counts detector match pulses over back-to-back windows of WINDOW cycles and
// offers each window's count on a valid/ready port via a one-deep result register.
module match_event_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             match_in,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             overflow,
  output logic             drop
);

  localparam int               WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = '1;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
    if (inc && (a != ACC_MAX)) return a + CNT_W'(1);
    return a;
  endfunction

  state_t           state_p0, state_nx;
  logic [CNT_W-1:0] acc_p0, acc_nx;
  logic             sat_p0, sat_nx;
  logic [WIN_W-1:0] win_p0, win_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             ovf_nx, vld_nx, drop_nx;

  logic [CNT_W-1:0] acc_upd;
  logic             sat_upd, win_end, take, load;

  assign acc_upd = sat_inc(acc_p0, match_in);
  assign sat_upd = sat_p0 | (match_in & (acc_p0 == ACC_MAX));
  assign win_end = (state_p0 == RUN) && enable && (win_p0 == WIN_LAST);
  assign take    = count_valid & count_ready;
  assign load    = win_end & (~count_valid | count_ready);

  always_comb begin
    state_nx = state_p0;
    acc_nx   = acc_p0;
    sat_nx   = sat_p0;
    win_nx   = win_p0;
    cnt_nx   = count_out;
    ovf_nx   = overflow;
    vld_nx   = count_valid;
    drop_nx  = 1'b0;
    if (take) vld_nx = 1'b0;
    if (clear) begin
      acc_nx = '0;
      sat_nx = 1'b0;
      win_nx = '0;
      vld_nx = 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (enable) begin
            state_nx = RUN;
            acc_nx   = '0;
            sat_nx   = 1'b0;
            win_nx   = '0;
          end
        end
        RUN: begin
          if (!enable) begin
            state_nx = IDLE;
            acc_nx   = '0;
            sat_nx   = 1'b0;
            win_nx   = '0;
          end else if (win_end) begin
            acc_nx = '0;
            sat_nx = 1'b0;
            win_nx = '0;
            if (load) begin
              cnt_nx = acc_upd;
              ovf_nx = sat_upd;
              vld_nx = 1'b1;
            end else begin
              drop_nx = 1'b1;
            end
          end else begin
            acc_nx = acc_upd;
            sat_nx = sat_upd;
            win_nx = win_p0 + WIN_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // stage p0: window accumulator and result register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_p0    <= IDLE;
      acc_p0      <= '0;
      sat_p0      <= 1'b0;
      win_p0      <= '0;
      count_out   <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
      drop        <= 1'b0;
    end else begin
      state_p0    <= state_nx;
      acc_p0      <= acc_nx;
      sat_p0      <= sat_nx;
      win_p0      <= win_nx;
      count_out   <= cnt_nx;
      overflow    <= ovf_nx;
      count_valid <= vld_nx;
      drop        <= drop_nx;
    end
  end

endmodule
